// File: rtl/sevenseg_scan_arbiter_if.sv
// Display bus between the requesters and the seven-segment scan arbiter.
interface sevenseg_scan_arbiter_if;
  logic [2:0]  req;
  logic [31:0] val0;
  logic [31:0] val1;
  logic [31:0] val2;
  logic        lz_en;
  logic [2:0]  grant;
  logic [7:0]  an;
  logic [6:0]  sev_out;
  logic        frame_done;

  // Requester side: drives requests and values, observes the display.
  modport master (
    output req, val0, val1, val2, lz_en,
    input  grant, an, sev_out, frame_done
  );

  // Arbiter side.
  modport slave (
    input  req, val0, val1, val2, lz_en,
    output grant, an, sev_out, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_arbiter.sv
// Frame-synchronous arbiter and 8-digit multiplexed scanner for the
// seven-segment display. Grant, snapshot and leading-zero mode change only
// at frame boundaries so a frame never tears.
module sevenseg_scan_arbiter #(
  parameter int unsigned BLANK_TICKS = 1,
  parameter int unsigned DRIVE_TICKS = 4,
  parameter int unsigned HOLD_FRAMES = 16
) (
  input  logic                    clk_7seg,
  input  logic                    Rst,
  sevenseg_scan_arbiter_if.slave  bus
);

  localparam int unsigned MAX_TICKS = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
  localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int unsigned HW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [TW-1:0] BLANK_LAST  = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] DRIVE_LAST  = TW'(DRIVE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_FRAMES - 1);

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    dig, dig_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic          arb_c;

  logic [2:0]    grant_q, grant_nxt;
  logic [31:0]   snap_q, snap_nxt;
  logic [HW-1:0] hold_q, hold_nxt;
  logic          lz_q, lz_nxt;

  logic [7:0]    an_q, an_nxt;
  logic [6:0]    sev_q, sev_nxt;
  logic          fd_q, fd_nxt;

  logic [2:0]    msd_c;
  logic [3:0]    nib_c;
  logic          lit_c;

  // Nibble to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Scan state register.
  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      state <= S_IDLE;
      dig   <= 3'd0;
      tick  <= '0;
    end else begin
      state <= state_nxt;
      dig   <= dig_nxt;
      tick  <= tick_nxt;
    end
  end

  // Scan sequencing: BLANK then DRIVE per digit, frame boundary after digit 7.
  always_comb begin
    state_nxt = state;
    dig_nxt   = dig;
    tick_nxt  = tick;
    arb_c     = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_BLANK;
        dig_nxt   = 3'd0;
        tick_nxt  = '0;
        arb_c     = 1'b1;
      end
      S_BLANK: begin
        if (tick == BLANK_LAST) begin
          state_nxt = S_DRIVE;
          tick_nxt  = '0;
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      S_DRIVE: begin
        if (tick == DRIVE_LAST) begin
          state_nxt = S_BLANK;
          tick_nxt  = '0;
          dig_nxt   = dig + 3'd1;
          arb_c     = (dig == 3'd7);
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        dig_nxt   = 3'd0;
        tick_nxt  = '0;
      end
    endcase
  end

  // Arbitration at frame boundaries; UART grant sticks for the hold window.
  always_comb begin
    grant_nxt = grant_q;
    snap_nxt  = snap_q;
    hold_nxt  = hold_q;
    lz_nxt    = lz_q;
    if (arb_c) begin
      lz_nxt = bus.lz_en;
      if (bus.req[2]) begin
        grant_nxt = 3'b100;
        snap_nxt  = bus.val2;
        hold_nxt  = '0;
      end else if (bus.req[1]) begin
        grant_nxt = 3'b010;
        snap_nxt  = bus.val1;
        hold_nxt  = HOLD_RELOAD;
      end else if ((grant_q == 3'b010) && (hold_q != '0)) begin
        hold_nxt  = hold_q - HW'(1);
      end else if (bus.req[0]) begin
        grant_nxt = 3'b001;
        snap_nxt  = bus.val0;
        hold_nxt  = '0;
      end else begin
        grant_nxt = 3'b000;
        hold_nxt  = '0;
      end
    end
  end

  // Most-significant non-zero nibble; digit 0 when the snapshot is zero.
  always_comb begin
    msd_c = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (snap_q[4*i +: 4] != 4'h0) msd_c = 3'(i);
    end
  end

  // Next-phase outputs. Snapshot/grant/lz are stable whenever DRIVE is
  // entered, so the registered copies are used directly.
  always_comb begin
    an_nxt  = AN_OFF;
    sev_nxt = SEG_OFF;
    fd_nxt  = 1'b0;
    nib_c   = snap_q[{dig_nxt, 2'b00} +: 4];
    lit_c   = (grant_q != 3'b000) && !(lz_q && (dig_nxt > msd_c));
    if (state_nxt == S_DRIVE) begin
      if (lit_c) begin
        an_nxt  = ~(8'b0000_0001 << dig_nxt);
        sev_nxt = seg_decode(nib_c);
      end
      fd_nxt = (dig_nxt == 3'd7) && (tick_nxt == DRIVE_LAST);
    end
  end

  // Arbitration state and registered display outputs.
  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      grant_q <= 3'b000;
      snap_q  <= '0;
      hold_q  <= '0;
      lz_q    <= 1'b0;
      an_q    <= AN_OFF;
      sev_q   <= SEG_OFF;
      fd_q    <= 1'b0;
    end else begin
      grant_q <= grant_nxt;
      snap_q  <= snap_nxt;
      hold_q  <= hold_nxt;
      lz_q    <= lz_nxt;
      an_q    <= an_nxt;
      sev_q   <= sev_nxt;
      fd_q    <= fd_nxt;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.an         = an_q;
  assign bus.sev_out    = sev_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_arbiter.sv
// Frame-level bench for sevenseg_scan_arbiter: each table row drives one
// frame and names the owner and value that frame must show.
module tb_sevenseg_scan_arbiter;

  localparam int unsigned BT = 1;
  localparam int unsigned DT = 2;
  localparam int unsigned HF = 3;
  localparam int unsigned DL = BT + DT;
  localparam int unsigned F  = 8 * DL;
  localparam int unsigned NF = 24;

  localparam logic [31:0] VP = 32'h0123_4567;
  localparam logic [31:0] VD = 32'hDEAD_BEEF;
  localparam logic [31:0] VA = 32'h0000_00A5;
  localparam logic [31:0] VX = 32'h89AB_CDEF;
  localparam logic [31:0] VF = 32'hFFFF_FFFF;

  logic clk_7seg = 1'b0;
  logic Rst;

  always #5 clk_7seg = ~clk_7seg;

  sevenseg_scan_arbiter_if bus ();

  sevenseg_scan_arbiter #(
    .BLANK_TICKS (BT),
    .DRIVE_TICKS (DT),
    .HOLD_FRAMES (HF)
  ) dut (
    .clk_7seg (clk_7seg),
    .Rst      (Rst),
    .bus      (bus)
  );

  typedef struct packed {
    logic [2:0] grant;
    logic [7:0] an;
    logic [6:0] sev;
    logic       fd;
  } obs_t;

  typedef struct {
    logic [2:0]  req;
    logic        lz;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [2:0]  mid_req;
    logic [31:0] mid_v0;
    logic [2:0]  exp_grant;
    logic [31:0] exp_val;
    logic        exp_lz;
  } frame_t;

  localparam obs_t RST_OBS = '{grant: 3'b000, an: 8'hFF, sev: 7'h7F, fd: 1'b0};

  obs_t   exp_q[$];
  frame_t tbl[NF];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;  default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  function automatic frame_t mk(input logic [2:0] req, input logic lz,
                                input logic [31:0] v0, input logic [31:0] v1,
                                input logic [31:0] v2, input logic [2:0] mid_req,
                                input logic [31:0] mid_v0, input logic [2:0] eg,
                                input logic [31:0] ev);
    frame_t f;
    f.req = req;  f.lz = lz;  f.v0 = v0;  f.v1 = v1;  f.v2 = v2;
    f.mid_req = mid_req;  f.mid_v0 = mid_v0;
    f.exp_grant = eg;  f.exp_val = ev;  f.exp_lz = lz;
    return f;
  endfunction

  // Expected display at frame position p (p=0 is the cycle after the boundary edge).
  function automatic obs_t scan_exp(input frame_t f, input int p);
    obs_t o;
    int   d, ph, top;
    logic [31:0] v;
    logic [3:0]  nib;
    v   = f.exp_val;
    d   = p / DL;
    ph  = p % DL;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      nib = v[4*i +: 4];
      if (nib != 4'h0) top = i;
    end
    o.grant = f.exp_grant;
    o.an    = 8'hFF;
    o.sev   = 7'h7F;
    o.fd    = (p == F - 1);
    if (ph >= BT && f.exp_grant != 3'b000 && !(f.exp_lz && d > top)) begin
      o.an  = ~(8'h01 << d);
      nib   = v[4*d +: 4];
      o.sev = seg(nib);
    end
    return o;
  endfunction

  // Advance one edge, then pop the oldest expectation and compare.
  task automatic step_check(input string tag, input int idx, input int p);
    obs_t e, got;
    @(posedge clk_7seg);
    #1;
    e   = exp_q.pop_front();
    got = '{grant: bus.grant, an: bus.an, sev: bus.sev_out, fd: bus.frame_done};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] p=%0d got grant=%b an=%h sev=%b fd=%b, exp grant=%b an=%h sev=%b fd=%b",
               tag, idx, p, got.grant, got.an, got.sev, got.fd, e.grant, e.an, e.sev, e.fd);
    end
  endtask

  // Drive one frame from a table row; stop early after 'ncyc' cycles.
  task automatic run_frame(input int idx, input int ncyc);
    frame_t f;
    f = tbl[idx];
    bus.req   = f.req;
    bus.lz_en = f.lz;
    bus.val0  = f.v0;
    bus.val1  = f.v1;
    bus.val2  = f.v2;
    for (int p = 0; p < ncyc; p++) begin
      exp_q.push_back(scan_exp(f, p));
      step_check("frame", idx, p);
      if (p == int'(F / 2)) begin
        bus.req  = f.mid_req;
        bus.val0 = f.mid_v0;
      end
    end
  endtask

  task automatic reset_cycles(input int n);
    Rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(RST_OBS);
      step_check("reset", i, 0);
    end
    Rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    //                req     lz    v0            v1   v2   mid_req mid_v0        grant   value
    tbl[0]  = mk(3'b001, 1'b0, VP,           VA,  VD,  3'b001, VP,           3'b001, VP);
    tbl[1]  = mk(3'b001, 1'b0, VP,           VA,  VD,  3'b001, VX,           3'b001, VP);
    tbl[2]  = mk(3'b001, 1'b0, VP,           VA,  VD,  3'b101, VP,           3'b001, VP);
    tbl[3]  = mk(3'b101, 1'b0, VP,           VA,  VD,  3'b101, VP,           3'b100, VD);
    tbl[4]  = mk(3'b011, 1'b0, VP,           VA,  VD,  3'b001, VP,           3'b010, VA);
    tbl[5]  = mk(3'b001, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b010, VA);
    tbl[6]  = mk(3'b001, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b010, VA);
    tbl[7]  = mk(3'b001, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b001, VP);
    tbl[8]  = mk(3'b001, 1'b0, VP,           VA,  VD,  3'b011, VP,           3'b001, VP);
    tbl[9]  = mk(3'b001, 1'b0, VP,           VA,  VD,  3'b001, VP,           3'b001, VP);
    tbl[10] = mk(3'b011, 1'b0, VP,           VA,  VD,  3'b001, VP,           3'b010, VA);
    tbl[11] = mk(3'b101, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b100, VD);
    tbl[12] = mk(3'b001, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b001, VP);
    tbl[13] = mk(3'b001, 1'b1, 32'h0000_0A05, VA, VD,  3'b001, 32'h0000_0A05, 3'b001, 32'h0000_0A05);
    tbl[14] = mk(3'b001, 1'b1, 32'h0,        VA,  VD,  3'b001, 32'h0,        3'b001, 32'h0);
    tbl[15] = mk(3'b001, 1'b0, 32'h0,        VA,  VD,  3'b001, 32'h0,        3'b001, 32'h0);
    tbl[16] = mk(3'b000, 1'b0, VP,           VA,  VD,  3'b000, VP,           3'b000, VP);
    tbl[17] = mk(3'b011, 1'b0, VP,           VA,  VD,  3'b001, VP,           3'b010, VA);
    tbl[18] = mk(3'b001, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b010, VA);
    tbl[19] = mk(3'b001, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b010, VA);
    tbl[20] = mk(3'b101, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b100, VD);
    tbl[21] = mk(3'b011, 1'b0, VP,           VA,  VD,  3'b001, VP,           3'b010, VA);
    tbl[22] = mk(3'b001, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b010, VA);
    tbl[23] = mk(3'b001, 1'b0, VP,           VF,  VD,  3'b001, VP,           3'b001, VP);

    Rst       = 1'b1;
    bus.req   = 3'b001;
    bus.lz_en = 1'b0;
    bus.val0  = VP;
    bus.val1  = VA;
    bus.val2  = VD;
    @(negedge clk_7seg);
    reset_cycles(2);

    // Full frames back to back: scan, preempt, hold, pulses, lz, idle.
    for (int i = 0; i <= 21; i++) run_frame(i, F);

    // Reset during DRIVE of digit 4 while the UART hold is active.
    run_frame(22, 4 * DL + BT + 1);
    reset_cycles(2);
    run_frame(23, F);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard leftover=%0d required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
